reset_sequencer: RTL and testbench

//  Parametrised power-on/pushbutton reset generator, successor to the single-output PoR.

---
 rtl/reset_seq_pkg.sv | 31 +++
 rtl/rst_debounce.sv | 54 +++++
 rtl/reset_sequencer.sv | 149 ++++++++++++++
 tb/tb_reset_sequencer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : reset_seq_pkg
// Brief   : State encoding, reset-cause codes and helpers for reset_sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package reset_seq_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_hold = 2'd0;
    localparam state_t c_st_rel  = 2'd1;
    localparam state_t c_st_run  = 2'd2;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'b00,
        CAUSE_PB   = 2'b01,
        CAUSE_WDOG = 2'b10
    } cause_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_debounce.sv
`default_nettype none
// ============================================================================
// Module  : rst_debounce
// Brief   : 2-flop synchroniser plus debounce filter; one-cycle pulse per press.
// Rev     : 1.0  initial release
// ============================================================================
module rst_debounce
    import reset_seq_pkg::*;
#(
    parameter int DB_CYCLES = 1024,
    parameter int CNT_W     = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic pb_n,
    output logic press
);

    localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= pb_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_db_last) begin
                // Only a 1->0 change of the filtered level is a press.
                r_stable <= r_sync2;
                r_press  <= r_stable;
                r_cnt    <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reset_sequencer
// Brief   : Power-on / pushbutton reset generator releasing NUM_CH resets in order.
// Options : define RST_SEQ_WDOG_EN to enable the RUN-state watchdog.
// Rev     : 1.0  initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int PRE_DLY     = 128,
    parameter int STAGE_DLY   = 16,
    parameter int DB_CYCLES   = 1024,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pb_n,
    input  logic              wdog_kick,
    output logic [NUM_CH-1:0] rst_out,
    output logic              done,
    output logic [1:0]        cause
);

    localparam int c_idx_w    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int c_cnt_need = max4(PRE_DLY, STAGE_DLY, DB_CYCLES, WDOG_CYCLES);

    localparam logic [CNT_W-1:0]   c_pre_last   = CNT_W'(PRE_DLY - 1);
    localparam logic [CNT_W-1:0]   c_stage_last = CNT_W'(STAGE_DLY - 1);
    localparam logic [c_idx_w-1:0] c_idx_last   = c_idx_w'((NUM_CH > 1) ? NUM_CH - 2 : 0);

    generate
        if ((NUM_CH < 1) || (NUM_CH > 16) || (PRE_DLY < 1) || (STAGE_DLY < 1) ||
            ((CNT_W < 31) && (c_cnt_need > ((1 << CNT_W) - 1)))) begin : g_param_check
            $error("reset_sequencer: CNT_W too small or parameter out of range");
        end
    endgenerate

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_idx_w-1:0]  r_idx;
    logic [NUM_CH-1:0]   r_rst_out;
    logic                r_done;
    cause_e              r_cause;

    logic                w_press;
    logic                w_wdog_expire;
    logic                w_restart;
    logic [CNT_W-1:0]    w_cnt_inc;

    rst_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .pb_n  (pb_n),
        .press (w_press)
    );

    assign w_restart = w_press | w_wdog_expire;
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

`ifdef RST_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] c_wdog_last = CNT_W'(WDOG_CYCLES - 1);

    logic [CNT_W-1:0] r_wdog_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog_cnt <= '0;
        end else if ((r_state != c_st_run) || w_restart || wdog_kick) begin
            r_wdog_cnt <= '0;
        end else if (r_wdog_cnt != '1) begin
            r_wdog_cnt <= r_wdog_cnt + 1'b1;
        end
    end

    // A kick on the expiry edge still counts as a kick.
    assign w_wdog_expire = (r_state == c_st_run) && !wdog_kick && (r_wdog_cnt == c_wdog_last);
`else
    logic w_unused_kick;
    assign w_unused_kick = wdog_kick;
    assign w_wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_st_hold;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_cause   <= CAUSE_POR;
        end else if (w_restart) begin
            // Pushbutton takes precedence when both sources fire together.
            r_state   <= c_st_hold;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_rst_out <= '1;
            r_done    <= 1'b0;
            r_cause   <= w_press ? CAUSE_PB : CAUSE_WDOG;
        end else begin
            case (r_state)
                c_st_hold: begin
                    if (r_cnt == c_pre_last) begin
                        r_cnt     <= '0;
                        r_rst_out <= r_rst_out << 1;
                        if (NUM_CH == 1) begin
                            r_state <= c_st_run;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= c_st_rel;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_st_rel: begin
                    if (r_cnt == c_stage_last) begin
                        // Released bits are the low zeros, so a left shift frees the next channel.
                        r_cnt     <= '0;
                        r_rst_out <= r_rst_out << 1;
                        r_idx     <= r_idx + 1'b1;
                        if (r_idx == c_idx_last) begin
                            r_state <= c_st_run;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                c_st_run: begin
                end
                default: begin
                    r_state <= c_st_hold;
                end
            endcase
        end
    end

    assign rst_out = r_rst_out;
    assign done    = r_done;
    assign cause   = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reset_sequencer
// Brief   : Randomised self-checking bench for reset_sequencer against a timing model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int NCH   = 4;
    localparam int PRE   = 8;
    localparam int STG   = 4;
    localparam int DB    = 10;
    localparam int WD    = 32;
    localparam int CW    = 16;
    localparam int T_RUN = PRE + (NCH - 1) * STG;

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           pb_n      = 1'b1;
    logic           pb_idle   = 1'b1;
    logic           wdog_kick = 1'b0;
    logic [NCH-1:0] rst_out;
    logic           done;
    logic [1:0]     cause;
    logic [0:0]     rst_out1;
    logic           done1;
    logic [1:0]     cause1;

    reset_sequencer #(
        .NUM_CH(NCH), .CNT_W(CW), .PRE_DLY(PRE), .STAGE_DLY(STG),
        .DB_CYCLES(DB), .WDOG_CYCLES(WD)
    ) u_dut (
        .clk(clk), .reset(reset), .pb_n(pb_n), .wdog_kick(wdog_kick),
        .rst_out(rst_out), .done(done), .cause(cause)
    );

    reset_sequencer #(
        .NUM_CH(1), .CNT_W(CW), .PRE_DLY(PRE), .STAGE_DLY(STG),
        .DB_CYCLES(DB), .WDOG_CYCLES(WD)
    ) u_dut_single (
        .clk(clk), .reset(reset), .pb_n(pb_idle), .wdog_kick(wdog_kick),
        .rst_out(rst_out1), .done(done1), .cause(cause1)
    );

    always #5 clk = ~clk;

    int   checks    = 0;
    int   failures  = 0;
    int   n         = 0;
    int   seq_start = 0;
    int   cause_m   = 0;
    int   last_kick = -1;
    bit   press_pend = 1'b0;
    bit   stable_m   = 1'b1;
    bit   lat_q[$];
    bit   win_q[$];

    int         dir_k[5] = '{7, 8, 12, 16, 20};
    logic [3:0] dir_r[5] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0};
    logic       blvl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    int         blen[4]  = '{2, 1, 3, 2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    function automatic int released(input int k);
        int r;
        if (k < PRE) return 0;
        r = 1 + (k - PRE) / STG;
        return (r > NCH) ? NCH : r;
    endfunction

    function automatic logic [NCH-1:0] exp_rst(input int k);
        logic [NCH-1:0] v;
        v = '1;
        return v << released(k);
    endfunction

    task automatic model_reset();
        seq_start  = n;
        cause_m    = 0;
        last_kick  = -1;
        press_pend = 1'b0;
        stable_m   = 1'b1;
        lat_q.delete();
        lat_q.push_back(1'b1);
        lat_q.push_back(1'b1);
        win_q.delete();
    endtask

    // Sequence timing is a function of edges since the last (re)start; the button
    // is accepted after DB consecutive differing samples seen two edges late.
    task automatic model_step();
        int  k_prev;
        bit  expire;
        bit  s;
        bit  all_diff;
        k_prev = n - 1 - seq_start;
        expire = 1'b0;
`ifdef RST_SEQ_WDOG_EN
        if (k_prev >= T_RUN) begin
            int base;
            base = seq_start + T_RUN;
            if (last_kick > base) base = last_kick;
            if (wdog_kick) last_kick = n;
            else if ((n - 1 - base) == WD - 1) expire = 1'b1;
        end
`endif
        if (press_pend || expire) begin
            seq_start = n;
            cause_m   = press_pend ? 1 : 2;
            last_kick = -1;
        end
        s = lat_q.pop_front();
        lat_q.push_back(pb_n);
        press_pend = 1'b0;
        win_q.push_back(s);
        if (win_q.size() > DB) void'(win_q.pop_front());
        if (win_q.size() == DB) begin
            all_diff = 1'b1;
            foreach (win_q[i]) if (win_q[i] == stable_m) all_diff = 1'b0;
            if (all_diff) begin
                press_pend = stable_m;
                stable_m   = !stable_m;
                win_q.delete();
            end
        end
    endtask

    task automatic compare_all();
        int k;
        k = n - seq_start;
        check("rst_out", rst_out, exp_rst(k));
        check("done", done, released(k) == NCH);
        check("cause", cause, cause_m);
    endtask

    task automatic tick();
        @(posedge clk);
        n++;
        if (reset) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    initial begin
        int c_last;
        int t_restart;
        int hold;
        int lk;

        model_reset();
        repeat (3) tick();
        check("por_rst1", rst_out1, 1);
        check("por_done1", done1, 0);
        check("por_cause1", cause1, 0);
        reset = 1'b0;

        // Power-up release sequence, plus the single-channel instance.
        for (int i = 0; i < 25; i++) begin
            tick();
            for (int j = 0; j < 5; j++)
                if (n - seq_start == dir_k[j]) check("seq_dir", rst_out, dir_r[j]);
            if (n - seq_start == PRE - 1) begin
                check("n1_rst_pre", rst_out1, 1);
                check("n1_done_pre", done1, 0);
            end
            if (n - seq_start == PRE) begin
                check("n1_rst_rel", rst_out1, 0);
                check("n1_done_rel", done1, 1);
            end
            if (n - seq_start == T_RUN) check("done_edge", done, 1);
        end

        // Bouncy press in RUN.
        for (int b = 0; b < 4; b++) begin
            pb_n = blvl[b];
            repeat (blen[b]) tick();
        end
        pb_n      = 1'b0;
        c_last    = n;
        t_restart = c_last + DB + 3;
        while (n < t_restart - 1) begin
            wdog_kick = (n % 8 == 0);
            tick();
        end
        wdog_kick = 1'b0;
        check("pb_before_rst", rst_out, 4'h0);
        tick();
        check("pb_restart_rst", rst_out, 4'hF);
        check("pb_restart_cause", cause, 1);
        repeat (15) tick();
        pb_n = 1'b1;
        repeat (DB + 6) tick();

        // Press landing mid-release, then asynchronous reset mid-release.
        reset = 1'b1;
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        pb_n  = 1'b0;
        repeat (12) tick();
        check("rel_pre_press", rst_out, 4'hC);
        tick();
        check("rel_press_rst", rst_out, 4'hF);
        check("rel_press_cause", cause, 1);
        pb_n = 1'b1;
        repeat (13) tick();
        check("rel_again", rst_out, 4'hC);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst", rst_out, 4'hF);
        check("async_done", done, 0);
        check("async_cause", cause, 0);
        repeat (2) tick();
        reset = 1'b0;

`ifdef RST_SEQ_WDOG_EN
        repeat (T_RUN + WD - 1) tick();
        check("wd_pre_done", done, 1);
        check("wd_pre_cause", cause, 0);
        tick();
        check("wd_rst", rst_out, 4'hF);
        check("wd_cause", cause, 2);
        for (int i = 1; i <= 140; i++) begin
            wdog_kick = (i % 20 == 0);
            tick();
        end
        wdog_kick = 1'b0;
        check("wd_kick_done", done, 1);
        check("wd_kick_cause", cause, 2);
        lk = n;
        repeat (WD - DB - 3) tick();
        pb_n = 1'b0;
        while (n < lk + WD - 1) tick();
        check("wd_pb_pre_cause", cause, 2);
        tick();
        check("wd_pb_rst", rst_out, 4'hF);
        check("wd_pb_cause", cause, 1);
        pb_n = 1'b1;
        repeat (DB + 5) tick();
`else
        lk = 0;
`endif

        // Randomised button activity, kicks and occasional async resets.
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            if (hold == 0) begin
                pb_n = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 2 * DB + 4);
            end
            hold--;
            wdog_kick = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 499) == 0) begin
                #2;
                reset = 1'b1;
                model_reset();
                #1;
                compare_all();
                tick();
                reset = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
